// File: rtl/doorlock_pkg.sv
// Shared encodings for the keypad controller and the downstream output stage.
package doorlock_pkg;

    // Encodings seen on the 'state' output; the output stage decodes these.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ENTRY = 2'b01;
    localparam logic [1:0] ST_CHECK = 2'b10;

    // Control key values.
    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_ENT = 4'hB;

    // Decoded meaning of a key event.
    typedef enum logic [1:0] {
        KC_NONE = 2'd0,
        KC_BIT  = 2'd1,
        KC_CLR  = 2'd2,
        KC_ENT  = 2'd3
    } key_class_e;

    // Map a raw key value onto its class; unknown values decode as KC_NONE.
    function automatic key_class_e classify_key(input logic [3:0] code);
        key_class_e kc;
        case (code)
            4'h0, 4'h1: kc = KC_BIT;
            KEY_CLR:    kc = KC_CLR;
            KEY_ENT:    kc = KC_ENT;
            default:    kc = KC_NONE;
        endcase
        return kc;
    endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter shared by the ENTRY, CHECK and LOCKOUT phases.
// 'done' is high during the last cycle of a loaded interval, so a load at
// edge N with value V lets the owner act at edge N+V.
module doorlock_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == WIDTH'(1));

endmodule

// File: rtl/doorlock_keypad.sv
// Keypad entry controller: collects a 4-bit code, holds it for the check
// window, counts wrong attempts, enforces lockout and times out idle entries.
module doorlock_keypad
    import doorlock_pkg::*;
#(
    parameter logic [3:0]  PASSCODE      = 4'b1101,
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned CHECK_CYCLES  = 500,
    parameter int unsigned LOCK_CYCLES   = 2000,
    parameter int unsigned ENTRY_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [1:0] state,
    output logic [3:0] ps_num,
    output logic       locked_out,
    output logic [2:0] fail_cnt
);

    localparam int unsigned MAX_CL  = (CHECK_CYCLES > LOCK_CYCLES) ? CHECK_CYCLES : LOCK_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_CL > ENTRY_TIMEOUT) ? MAX_CL : ENTRY_TIMEOUT;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_TIMEOUT);
    localparam logic [TW-1:0] T_CHECK = TW'(CHECK_CYCLES);
    localparam logic [TW-1:0] T_LOCK  = TW'(LOCK_CYCLES);
    localparam logic [2:0]    TRIES   = 3'(MAX_TRIES);

    // Internal FSM; LOCKOUT has its own code but shows as ST_IDLE outside.
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ENTRY = 2'b01;
    localparam logic [1:0] S_CHECK = 2'b10;
    localparam logic [1:0] S_LOCK  = 2'b11;

    logic [1:0]    fsm, fsm_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic          chk_first, chk_first_n;
    logic [3:0]    ps_n;
    logic [2:0]    fail_n;
    logic [1:0]    state_n;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    key_class_e    kc;

    doorlock_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state, datapath and timer-control decisions for the current cycle.
    always_comb begin
        fsm_n       = fsm;
        bit_cnt_n   = bit_cnt;
        ps_n        = ps_num;
        fail_n      = fail_cnt;
        chk_first_n = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        kc          = key_valid ? classify_key(key_code) : KC_NONE;

        case (fsm)
            S_IDLE: begin
                if (kc == KC_BIT) begin
                    ps_n      = {3'b000, key_code[0]};
                    bit_cnt_n = 3'd1;
                    fsm_n     = S_ENTRY;
                    tmr_load  = 1'b1;
                    tmr_val   = T_ENTRY;
                end
            end

            S_ENTRY: begin
                if (key_valid) begin
                    // Every key, accepted or not, restarts the idle timeout.
                    tmr_load = 1'b1;
                    tmr_val  = T_ENTRY;
                    case (kc)
                        KC_BIT: begin
                            if (bit_cnt < 3'd4) begin
                                ps_n      = {ps_num[2:0], key_code[0]};
                                bit_cnt_n = bit_cnt + 3'd1;
                            end
                        end
                        KC_CLR: begin
                            ps_n      = '0;
                            bit_cnt_n = '0;
                            fsm_n     = S_IDLE;
                            tmr_val   = '0;
                        end
                        KC_ENT: begin
                            if (bit_cnt == 3'd4) begin
                                fsm_n       = S_CHECK;
                                chk_first_n = 1'b1;
                                tmr_val     = T_CHECK;
                            end
                        end
                        default: ;
                    endcase
                end else if (tmr_done) begin
                    ps_n      = '0;
                    bit_cnt_n = '0;
                    fsm_n     = S_IDLE;
                    tmr_load  = 1'b1;
                    tmr_val   = '0;
                end
            end

            S_CHECK: begin
                // The attempt is scored one edge after entering CHECK; the exit
                // decision below uses the freshly scored count so that a
                // one-cycle window still sees it.
                if (chk_first) begin
                    if (ps_num == PASSCODE) begin
                        fail_n = '0;
                    end else if (fail_cnt != 3'd7) begin
                        fail_n = fail_cnt + 3'd1;
                    end
                end
                if (tmr_done) begin
                    ps_n      = '0;
                    bit_cnt_n = '0;
                    tmr_load  = 1'b1;
                    if (fail_n >= TRIES) begin
                        fsm_n   = S_LOCK;
                        tmr_val = T_LOCK;
                    end else begin
                        fsm_n   = S_IDLE;
                        tmr_val = '0;
                    end
                end
            end

            S_LOCK: begin
                if (tmr_done) begin
                    fail_n   = '0;
                    fsm_n    = S_IDLE;
                    tmr_load = 1'b1;
                    tmr_val  = '0;
                end
            end

            default: begin
                fsm_n = S_IDLE;
            end
        endcase
    end

    // Translate the internal state into the external encoding.
    always_comb begin
        case (fsm_n)
            S_ENTRY: state_n = ST_ENTRY;
            S_CHECK: state_n = ST_CHECK;
            default: state_n = ST_IDLE;
        endcase
    end

    // Register FSM, datapath and all outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= S_IDLE;
            bit_cnt    <= '0;
            chk_first  <= 1'b0;
            ps_num     <= '0;
            fail_cnt   <= '0;
            state      <= ST_IDLE;
            locked_out <= 1'b0;
        end else begin
            fsm        <= fsm_n;
            bit_cnt    <= bit_cnt_n;
            chk_first  <= chk_first_n;
            ps_num     <= ps_n;
            fail_cnt   <= fail_n;
            state      <= state_n;
            locked_out <= (fsm_n == S_LOCK);
        end
    end

endmodule
